// File: rtl/hazard_controller.sv
// hazard_controller: operand forwarding, load-use stall and redirect flush
// control for a 5-stage RV32I pipeline, with a small status FSM and
// saturating stall/flush event counters.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_RS1,
    input  logic [4:0]       IF_ID_RS2,
    input  logic [4:0]       ID_EX_RS1,
    input  logic [4:0]       ID_EX_RS2,
    input  logic [4:0]       ID_EX_RD,
    input  logic             ID_EX_regwrite_en,
    input  logic             ID_EX_wb_sel,
    input  logic [4:0]       EX_MEM_RD,
    input  logic             EX_MEM_regwrite_en,
    input  logic             EX_MEM_wb_sel,
    input  logic [4:0]       MEM_WB_RD,
    input  logic             MEM_WB_regwrite_en,
    input  logic             PC_sel,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [4:0] ex_rs    [2];
    logic [1:0] fwd_sel  [2];
    logic       mem_fwd_ok;
    logic       wb_fwd_ok;
    logic       load_use;

    assign ex_rs[0] = ID_EX_RS1;
    assign ex_rs[1] = ID_EX_RS2;

    // A load in MEM has no ALU result yet, so it never forwards from MEM.
    assign mem_fwd_ok = EX_MEM_regwrite_en && !EX_MEM_wb_sel && (EX_MEM_RD != 5'd0);
    assign wb_fwd_ok  = MEM_WB_regwrite_en && (MEM_WB_RD != 5'd0);

    // Per-operand forward select; the younger MEM result wins over WB.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = rst                                     ? 2'b00 :
                                 (mem_fwd_ok && EX_MEM_RD == ex_rs[gi]) ? 2'b10 :
                                 (wb_fwd_ok  && MEM_WB_RD == ex_rs[gi]) ? 2'b01 :
                                                                          2'b00;
        end
    endgenerate

    assign forwardAE = fwd_sel[0];
    assign forwardBE = fwd_sel[1];

    assign load_use = ID_EX_wb_sel && ID_EX_regwrite_en && (ID_EX_RD != 5'd0) &&
                      ((ID_EX_RD == IF_ID_RS1) || (ID_EX_RD == IF_ID_RS2));

    // Stall/flush actions; a redirect squashes the wrong path and overrides load-use.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        if (!rst) begin
            if (PC_sel) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
                flush_M = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    // Next state reflects which action this cycle takes.
    always_comb begin
        state_next = RUN;
        if (PC_sel) begin
            state_next = FLUSH;
        end else if (load_use) begin
            state_next = STALL;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    assign ctrl_state = state_reg;

    // Saturating event counters; stall_D/flush_M already encode the action taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_D && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_M && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: directed test-plan steps followed by
// randomized traffic, checked against a rule-level reference model.
module tb_hazard_controller;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    IF_ID_RS1, IF_ID_RS2, ID_EX_RS1, ID_EX_RS2, ID_EX_RD;
    logic          ID_EX_regwrite_en, ID_EX_wb_sel;
    logic [4:0]    EX_MEM_RD;
    logic          EX_MEM_regwrite_en, EX_MEM_wb_sel;
    logic [4:0]    MEM_WB_RD;
    logic          MEM_WB_regwrite_en, PC_sel;
    logic [1:0]    forwardAE, forwardBE, ctrl_state;
    logic          stall_F, stall_D, flush_D, flush_E, flush_M;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state: last action taken and event totals.
    int m_state = 0;
    int m_stalls = 0;
    int m_flushes = 0;

    hazard_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2),
        .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_RD(ID_EX_RD),
        .ID_EX_regwrite_en(ID_EX_regwrite_en), .ID_EX_wb_sel(ID_EX_wb_sel),
        .EX_MEM_RD(EX_MEM_RD), .EX_MEM_regwrite_en(EX_MEM_regwrite_en),
        .EX_MEM_wb_sel(EX_MEM_wb_sel),
        .MEM_WB_RD(MEM_WB_RD), .MEM_WB_regwrite_en(MEM_WB_regwrite_en),
        .PC_sel(PC_sel),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stall_F(stall_F), .stall_D(stall_D),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
        .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Which source the EX operand should take, by the forwarding rules.
    function automatic int exp_fwd(input logic [4:0] rs);
        if (rst) return 0;
        if (EX_MEM_regwrite_en && !EX_MEM_wb_sel && EX_MEM_RD != 0 && EX_MEM_RD == rs) return 2;
        if (MEM_WB_regwrite_en && MEM_WB_RD != 0 && MEM_WB_RD == rs) return 1;
        return 0;
    endfunction

    function automatic bit exp_lu();
        return ID_EX_wb_sel && ID_EX_regwrite_en && ID_EX_RD != 0 &&
               (ID_EX_RD == IF_ID_RS1 || ID_EX_RD == IF_ID_RS2);
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic clear_inputs();
        IF_ID_RS1 = 0; IF_ID_RS2 = 0; ID_EX_RS1 = 0; ID_EX_RS2 = 0; ID_EX_RD = 0;
        ID_EX_regwrite_en = 0; ID_EX_wb_sel = 0;
        EX_MEM_RD = 0; EX_MEM_regwrite_en = 0; EX_MEM_wb_sel = 0;
        MEM_WB_RD = 0; MEM_WB_regwrite_en = 0; PC_sel = 0;
    endtask

    // One cycle: check every output against the model at negedge, then advance the model at posedge.
    task automatic cycle(input string tag);
        bit lu, redirect, stall;
        @(negedge clk);
        lu       = exp_lu();
        redirect = !rst && PC_sel;
        stall    = !rst && !PC_sel && lu;
        chk({tag, ".fwdA"},   forwardAE,  exp_fwd(ID_EX_RS1));
        chk({tag, ".fwdB"},   forwardBE,  exp_fwd(ID_EX_RS2));
        chk({tag, ".stallF"}, stall_F,    stall);
        chk({tag, ".stallD"}, stall_D,    stall);
        chk({tag, ".flushD"}, flush_D,    redirect);
        chk({tag, ".flushE"}, flush_E,    redirect || stall);
        chk({tag, ".flushM"}, flush_M,    redirect);
        chk({tag, ".state"},  ctrl_state, m_state);
        chk({tag, ".scnt"},   stall_cnt,  sat(m_stalls));
        chk({tag, ".fcnt"},   flush_cnt,  sat(m_flushes));
        $display("[TB] %s rst=%0b pc_sel=%0b lu=%0b fA=%0d fB=%0d state=%0d scnt=%0d fcnt=%0d",
                 tag, rst, PC_sel, lu, forwardAE, forwardBE, ctrl_state, stall_cnt, flush_cnt);
        @(posedge clk);
        if (rst) begin
            m_state = 0; m_stalls = 0; m_flushes = 0;
        end else if (PC_sel) begin
            m_state = 2; m_flushes++;
        end else if (lu) begin
            m_state = 1; m_stalls++;
        end else begin
            m_state = 0;
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        cycle("reset0");
        cycle("reset1");
        rst = 1'b0;

        // Forwarding priority: MEM over WB, then WB once MEM stops writing.
        EX_MEM_RD = 5; MEM_WB_RD = 5; EX_MEM_regwrite_en = 1; MEM_WB_regwrite_en = 1;
        ID_EX_RS1 = 5; ID_EX_RS2 = 6;
        #1; chk("prio.fwdA_mem", forwardAE, 2); chk("prio.fwdB_rf", forwardBE, 0);
        cycle("prio_mem");
        EX_MEM_regwrite_en = 0;
        #1; chk("prio.fwdA_wb", forwardAE, 1);
        cycle("prio_wb");

        // x0 never forwards; a load in MEM never forwards from MEM.
        clear_inputs();
        EX_MEM_regwrite_en = 1; MEM_WB_regwrite_en = 1;
        #1; chk("x0.fwdA", forwardAE, 0); chk("x0.fwdB", forwardBE, 0);
        cycle("x0");
        clear_inputs();
        EX_MEM_regwrite_en = 1; EX_MEM_wb_sel = 1; EX_MEM_RD = 7; ID_EX_RS2 = 7;
        #1; chk("ldmem.fwdB", forwardBE, 0);
        cycle("ldmem");

        // Load-use: one stall cycle, then the bubble reaches EX.
        clear_inputs();
        ID_EX_wb_sel = 1; ID_EX_regwrite_en = 1; ID_EX_RD = 3; IF_ID_RS2 = 3;
        #1; chk("lu.stallF", stall_F, 1); chk("lu.flushD", flush_D, 0);
        cycle("loaduse");
        chk("lu.state", ctrl_state, 1); chk("lu.scnt", stall_cnt, 1);
        clear_inputs();
        EX_MEM_RD = 3; EX_MEM_regwrite_en = 1; EX_MEM_wb_sel = 1;
        cycle("bubble");
        clear_inputs();
        MEM_WB_RD = 3; MEM_WB_regwrite_en = 1; ID_EX_RS2 = 3;
        #1; chk("lu.fwd_wb", forwardBE, 1);
        cycle("lu_fwd");

        // Redirect beats a simultaneous load-use.
        clear_inputs();
        ID_EX_wb_sel = 1; ID_EX_regwrite_en = 1; ID_EX_RD = 4; IF_ID_RS1 = 4; PC_sel = 1;
        #1; chk("redir.stallF", stall_F, 0); chk("redir.flushM", flush_M, 1);
        cycle("redirect");
        chk("redir.state", ctrl_state, 2); chk("redir.fcnt", flush_cnt, 1);
        chk("redir.scnt", stall_cnt, 1);

        // Saturation: 20 back-to-back redirects on a 4-bit counter.
        for (int i = 0; i < 20; i++) cycle("sat");
        chk("sat.fcnt", flush_cnt, SAT);

        // Reset mid-operation after two flushes, during a load-use stall.
        clear_inputs(); rst = 1; cycle("clr"); rst = 0;
        PC_sel = 1; cycle("fl1"); cycle("fl2");
        chk("mid.fcnt2", flush_cnt, 2);
        clear_inputs();
        ID_EX_wb_sel = 1; ID_EX_regwrite_en = 1; ID_EX_RD = 9; IF_ID_RS1 = 9;
        cycle("stall_pre");
        rst = 1;
        #1; chk("mid.stallD", stall_D, 0); chk("mid.flushE", flush_E, 0);
        cycle("rst_mid");
        chk("mid.state", ctrl_state, 0); chk("mid.scnt", stall_cnt, 0); chk("mid.fcnt", flush_cnt, 0);
        rst = 0;

        // Randomized traffic over a small register window to provoke matches.
        for (int i = 0; i < 400; i++) begin
            IF_ID_RS1 = 5'($urandom_range(0, 3)); IF_ID_RS2 = 5'($urandom_range(0, 3));
            ID_EX_RS1 = 5'($urandom_range(0, 3)); ID_EX_RS2 = 5'($urandom_range(0, 3));
            ID_EX_RD  = 5'($urandom_range(0, 3));
            ID_EX_regwrite_en  = 1'($urandom); ID_EX_wb_sel  = 1'($urandom);
            EX_MEM_RD = 5'($urandom_range(0, 3));
            EX_MEM_regwrite_en = 1'($urandom); EX_MEM_wb_sel = 1'($urandom);
            MEM_WB_RD = 5'($urandom_range(0, 3));
            MEM_WB_regwrite_en = 1'($urandom);
            PC_sel = ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 39) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
